// File: rtl/game_ctrl.sv
// Pong-style game sequencer: edge-detected hit/miss/press events drive IDLE/PLAY/SERVE/OVER and BCD scoring.
// Optional serve hold-off timer enabled by defining GAME_CTRL_SERVE_TIMER_EN.
module game_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       refresh_tick,
  input  logic       l_hit,
  input  logic       r_hit,
  input  logic       l_mis,
  input  logic       r_mis,
  output logic       gra_still,
  output logic [7:0] l_score,
  output logic [7:0] r_score,
  output logic [7:0] rally,
  output logic [1:0] winner,
  output logic [1:0] state
);

  // state | meaning
  // IDLE  | waiting for a press to start a new game
  // PLAY  | ball in motion, hits and misses counted
  // SERVE | ball frozen after a point, waits for timer and a press
  // OVER  | a side reached WIN_SCORE, waits for a press
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, SERVE = 2'b10, OVER = 2'b11} state_t;

  localparam int TW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [7:0] WIN_BCD = 8'(((WIN_SCORE / 10) << 4) + (WIN_SCORE % 10));

  state_t     st_q, st_d;
  logic [4:0] in_q, in_prev, ev;
  logic       press_e, hit_e, lm_e, rm_e;
  logic [7:0] ls_d, rs_d, rally_d;
  logic [1:0] win_d;
  logic [TW-1:0] timer_q;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // bit order: press, l_hit, r_hit, l_mis, r_mis
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q    <= '0;
      in_prev <= '0;
    end else begin
      in_q    <= {|btn, l_hit, r_hit, l_mis, r_mis};
      in_prev <= in_q;
    end
  end

  assign ev      = in_q & ~in_prev;
  assign press_e = ev[4];
  assign hit_e   = ev[3] | ev[2];
  assign lm_e    = ev[1];
  assign rm_e    = ev[0];

`ifdef GAME_CTRL_SERVE_TIMER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer_q <= '0;
    else if (st_q == PLAY && st_d == SERVE)
      timer_q <= TW'(SERVE_FRAMES);
    else if (st_q == SERVE && refresh_tick && timer_q != '0)
      timer_q <= timer_q - 1'b1;
  end
`else
  logic unused_tick;
  assign unused_tick = refresh_tick;
  assign timer_q     = '0;
`endif

  always_comb begin
    st_d    = st_q;
    ls_d    = l_score;
    rs_d    = r_score;
    rally_d = rally;
    win_d   = winner;
    case (st_q)
      IDLE: if (press_e) begin
        st_d    = PLAY;
        ls_d    = '0;
        rs_d    = '0;
        rally_d = '0;
        win_d   = 2'b00;
      end
      PLAY: begin
        // a miss outranks any hit in the same cycle
        if (lm_e && rm_e) begin
          st_d    = SERVE;
          rally_d = '0;
        end else if (lm_e) begin
          rs_d = bcd_inc(r_score);
          if (rs_d == WIN_BCD) begin
            st_d  = OVER;
            win_d = 2'b10;
          end else begin
            st_d    = SERVE;
            rally_d = '0;
          end
        end else if (rm_e) begin
          ls_d = bcd_inc(l_score);
          if (ls_d == WIN_BCD) begin
            st_d  = OVER;
            win_d = 2'b01;
          end else begin
            st_d    = SERVE;
            rally_d = '0;
          end
        end else if (hit_e && rally != 8'hFF) begin
          rally_d = rally + 8'd1;
        end
      end
      SERVE: if (press_e && timer_q == '0) st_d = PLAY;
      OVER: if (press_e) begin
        st_d  = IDLE;
        win_d = 2'b00;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= IDLE;
      gra_still <= 1'b1;
      l_score   <= '0;
      r_score   <= '0;
      rally     <= '0;
      winner    <= 2'b00;
    end else begin
      st_q      <= st_d;
      gra_still <= (st_d != PLAY);
      l_score   <= ls_d;
      r_score   <= rs_d;
      rally     <= rally_d;
      winner    <= win_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized play against a rule-level model.
module tb_game_ctrl;
  localparam int WIN = 11;
  localparam int SF  = 3;
`ifdef GAME_CTRL_SERVE_TIMER_EN
  localparam int M_SF = SF;
`else
  localparam int M_SF = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn = '0;
  logic       refresh_tick = 1'b0, l_hit = 1'b0, r_hit = 1'b0, l_mis = 1'b0, r_mis = 1'b0;
  logic       gra_still;
  logic [7:0] l_score, r_score, rally;
  logic [1:0] winner, state;

  int total = 0;
  int bad = 0;

  // model: scores as plain integers, events from a two-deep sample history
  int m_st, m_ls, m_rs, m_rally, m_win, m_timer;
  logic [4:0] m_cur, m_prev;

  game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SF)) dut (
    .clk(clk), .reset(reset), .btn(btn), .refresh_tick(refresh_tick),
    .l_hit(l_hit), .r_hit(r_hit), .l_mis(l_mis), .r_mis(r_mis),
    .gra_still(gra_still), .l_score(l_score), .r_score(r_score),
    .rally(rally), .winner(winner), .state(state)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = 0; m_ls = 0; m_rs = 0; m_rally = 0; m_win = 0; m_timer = 0;
    m_cur = '0; m_prev = '0;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic t, lh, rh, lm, rm);
    logic [4:0] e;
    e = m_cur & ~m_prev;
    case (m_st)
      0: if (e[4]) begin m_st = 1; m_ls = 0; m_rs = 0; m_rally = 0; m_win = 0; end
      1: begin
        if (e[1] && e[0]) begin
          m_st = 2; m_rally = 0; m_timer = M_SF;
        end else if (e[1]) begin
          m_rs = (m_rs < 99) ? m_rs + 1 : 99;
          if (m_rs == WIN) begin m_st = 3; m_win = 2; end
          else begin m_st = 2; m_rally = 0; m_timer = M_SF; end
        end else if (e[0]) begin
          m_ls = (m_ls < 99) ? m_ls + 1 : 99;
          if (m_ls == WIN) begin m_st = 3; m_win = 1; end
          else begin m_st = 2; m_rally = 0; m_timer = M_SF; end
        end else if ((e[3] || e[2]) && m_rally < 255) begin
          m_rally++;
        end
      end
      2: begin
        if (e[4] && m_timer == 0) m_st = 1;
        else if (t && m_timer > 0) m_timer--;
      end
      default: if (e[4]) begin m_st = 0; m_win = 0; end
    endcase
    m_prev = m_cur;
    m_cur  = {|b, lh, rh, lm, rm};
  endtask

  task automatic step(input logic [3:0] b, input logic t, lh, rh, lm, rm);
    btn = b; refresh_tick = t; l_hit = lh; r_hit = rh; l_mis = lm; r_mis = rm;
    @(posedge clk);
    #1;
    model_edge(b, t, lh, rh, lm, rm);
  endtask

  task automatic idle_step();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press();
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_step();
  endtask

  task automatic return_to_play();
    repeat (SF) step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press();
  endtask

  task automatic do_reset();
    btn = '0; refresh_tick = 0; l_hit = 0; r_hit = 0; l_mis = 0; r_mis = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", state); end
    total++; if (gra_still !== 1'b1) begin bad++; $display("FAIL reset_still got=%b want=1", gra_still); end
    total++; if ({l_score, r_score, rally, winner} !== 26'd0) begin bad++;
      $display("FAIL reset_regs got=%h/%h/%h/%b want=0", l_score, r_score, rally, winner); end
  endtask

  task automatic test_start();
    step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL start_latency got=%b want=00", state); end
    idle_step();
    total++; if (state !== 2'b01 || gra_still !== 1'b0) begin bad++;
      $display("FAIL start_play got=%b/%b want=01/0", state, gra_still); end
    total++; if (l_score !== 8'h00 || r_score !== 8'h00) begin bad++;
      $display("FAIL start_scores got=%h/%h want=00/00", l_score, r_score); end
  endtask

  task automatic test_rally();
    repeat (2) step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (rally !== 8'd1) begin bad++; $display("FAIL rally_first got=%0d want=1", rally); end
    repeat (4) step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (rally !== 8'd1) begin bad++; $display("FAIL rally_held got=%0d want=1", rally); end
    idle_step();
    step(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_step();
    total++; if (rally !== 8'd2) begin bad++; $display("FAIL rally_double got=%0d want=2", rally); end
  endtask

  task automatic test_miss_held();
    repeat (50) step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_step();
    total++; if (r_score !== 8'h01 || l_score !== 8'h00) begin bad++;
      $display("FAIL miss_held_score got=%h/%h want=00/01", l_score, r_score); end
    total++; if (state !== 2'b10 || rally !== 8'd0 || gra_still !== 1'b1) begin bad++;
      $display("FAIL miss_held_state got=%b rally=%0d still=%b want=10/0/1", state, rally, gra_still); end
  endtask

  task automatic test_serve();
`ifdef GAME_CTRL_SERVE_TIMER_EN
    press();
    total++; if (state !== 2'b10) begin bad++; $display("FAIL serve_early0 got=%b want=10", state); end
    repeat (2) step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press();
    total++; if (state !== 2'b10) begin bad++; $display("FAIL serve_early2 got=%b want=10", state); end
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    press();
`else
    press();
`endif
    total++; if (state !== 2'b01 || gra_still !== 1'b0) begin bad++;
      $display("FAIL serve_resume got=%b/%b want=01/0", state, gra_still); end
  endtask

  task automatic test_hit_miss();
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_step();
    total++; if (rally !== 8'd1) begin bad++; $display("FAIL hm_rally got=%0d want=1", rally); end
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_step();
    total++; if (r_score !== 8'h02 || state !== 2'b10 || rally !== 8'd0) begin bad++;
      $display("FAIL hit_miss got=r%h st=%b rally=%0d want=r02 st=10 rally=0", r_score, state, rally); end
    return_to_play();
  endtask

  task automatic test_double_miss();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();
    total++; if (l_score !== 8'h00 || r_score !== 8'h02 || state !== 2'b10) begin bad++;
      $display("FAIL double_miss got=%h/%h st=%b want=00/02 st=10", l_score, r_score, state); end
    return_to_play();
  endtask

  task automatic test_win();
    for (int i = 1; i <= 10; i++) begin
      step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_step();
      total++; if (l_score !== to_bcd(i) || state !== 2'b10) begin bad++;
        $display("FAIL win_count%0d got=%h st=%b want=%h st=10", i, l_score, state, to_bcd(i)); end
      return_to_play();
    end
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    total++; if (l_score !== 8'h11 || state !== 2'b11 || winner !== 2'b01 || gra_still !== 1'b1) begin bad++;
      $display("FAIL win_over got=%h st=%b win=%b still=%b want=11 st=11 win=01 still=1",
               l_score, state, winner, gra_still); end
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();
    total++; if (l_score !== 8'h11 || r_score !== 8'h02 || state !== 2'b11) begin bad++;
      $display("FAIL over_ignore got=%h/%h st=%b want=11/02 st=11", l_score, r_score, state); end
    press();
    total++; if (state !== 2'b00 || winner !== 2'b00 || l_score !== 8'h11) begin bad++;
      $display("FAIL over_exit got=st%b win=%b l=%h want=st00 win=00 l=11", state, winner, l_score); end
  endtask

  task automatic test_async_reset();
    press();
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    return_to_play();
    total++; if (l_score !== 8'h01 || state !== 2'b01) begin bad++;
      $display("FAIL pre_reset got=%h st=%b want=01 st=01", l_score, state); end
    #2 reset = 1'b1;
    model_reset();
    #1;
    total++; if (state !== 2'b00 || gra_still !== 1'b1 || {l_score, r_score, rally, winner} !== 26'd0) begin bad++;
      $display("FAIL async_reset got=st%b still=%b %h/%h rally=%h win=%b want=all reset", state, gra_still,
               l_score, r_score, rally, winner); end
    btn = 4'b1000;
    @(posedge clk);
    #4 reset = 1'b0;
    step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL held_first got=%b want=00", state); end
    step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 2'b01) begin bad++; $display("FAIL held_press got=%b want=01", state); end
    idle_step();
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic lh, rh, lm, rm, t;
    int shown;
    b = '0; lh = 0; rh = 0; lm = 0; rm = 0; shown = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) b = (b == 4'd0) ? 4'($urandom_range(15, 1)) : 4'd0;
      if ($urandom_range(3) == 0) lh = ~lh;
      if ($urandom_range(3) == 0) rh = ~rh;
      if ($urandom_range(39) == 0) lm = ~lm;
      if ($urandom_range(39) == 0) rm = ~rm;
      t = ($urandom_range(2) == 0);
      step(b, t, lh, rh, lm, rm);
      total++;
      if ({state, gra_still, l_score, r_score, rally, winner} !==
          {2'(m_st), (m_st != 1), to_bcd(m_ls), to_bcd(m_rs), 8'(m_rally), 2'(m_win)}) begin
        bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_cycle%0d got=st%b still=%b %h/%h rally=%0d win=%b want=st%0d %h/%h rally=%0d win=%0d",
                   n, state, gra_still, l_score, r_score, rally, winner, m_st, to_bcd(m_ls), to_bcd(m_rs),
                   m_rally, m_win);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_rally();
    test_miss_held();
    test_serve();
    test_hit_miss();
    test_double_miss();
    test_win();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
